asm_check_monitor: RTL

//  Synthesizable, parametrised assembly-test checker. Snoops CPU register-file writeback, keeps a shadow
//  RF, and runs a programmable check table: per entry, wait until the flag register reaches a value, then

---
 rtl/asm_check_if.sv | 41 ++++
 rtl/asm_check_monitor.sv | 170 +++++++++++++++++
 2 files changed

// File: rtl/asm_check_if.sv
// Snoop, check-table configuration and result signals shared between a CPU bench
// (or FPGA self-test wrapper) and asm_check_monitor.
interface asm_check_if #(
  parameter int NUM_CHECKS = 8,
  parameter int DWIDTH     = 32
);
  localparam int IDXW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;

  logic              wb_we;
  logic [4:0]        wb_addr;
  logic [DWIDTH-1:0] wb_data;

  logic              cfg_we;
  logic [IDXW-1:0]   cfg_idx;
  logic [DWIDTH-1:0] cfg_flag;
  logic [4:0]        cfg_reg;
  logic [DWIDTH-1:0] cfg_exp;
  logic [IDXW:0]     cfg_num;
  logic              start;

  logic              busy;
  logic              done;
  logic              pass;
  logic              fail;
  logic              timeout;
  logic [IDXW-1:0]   fail_idx;
  logic [DWIDTH-1:0] fail_got;
  logic [IDXW:0]     checks_passed;

  modport master (
    output wb_we, wb_addr, wb_data,
    output cfg_we, cfg_idx, cfg_flag, cfg_reg, cfg_exp, cfg_num, start,
    input  busy, done, pass, fail, timeout, fail_idx, fail_got, checks_passed
  );

  modport slave (
    input  wb_we, wb_addr, wb_data,
    input  cfg_we, cfg_idx, cfg_flag, cfg_reg, cfg_exp, cfg_num, start,
    output busy, done, pass, fail, timeout, fail_idx, fail_got, checks_passed
  );
endinterface

// File: rtl/asm_check_monitor.sv
// Assembly-test checker: shadows the CPU register file from writeback and walks a
// programmable table of (flag value, register, expected value) checks with a watchdog.
module asm_check_monitor #(
  parameter int NUM_CHECKS     = 8,
  parameter int DWIDTH         = 32,
  parameter int FLAG_REG       = 20,
  parameter int TIMEOUT_CYCLES = 100
) (
  input logic        clk,
  input logic        rst,
  asm_check_if.slave bus
);
  localparam int IDXW = (NUM_CHECKS > 1) ? $clog2(NUM_CHECKS) : 1;
  localparam int WDW  = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  localparam logic [4:0]     FLAG_ADDR = 5'(FLAG_REG);
  localparam logic [IDXW:0]  N_MAX     = (IDXW + 1)'(NUM_CHECKS);
  localparam logic [WDW-1:0] WD_LIMIT  = (TIMEOUT_CYCLES == 0) ? '0 : WDW'(TIMEOUT_CYCLES - 1);
  localparam logic [WDW-1:0] WD_SAT    = '1;

  typedef enum logic [2:0] {S_IDLE, S_WAIT, S_CMP, S_PASS, S_FAIL, S_TOUT} state_e;

  typedef struct packed {
    logic [DWIDTH-1:0] flag;
    logic [4:0]        rnum;
    logic [DWIDTH-1:0] exp;
  } entry_t;

  state_e            state_q, state_d;
  logic [IDXW-1:0]   idx_q, idx_d;
  logic [IDXW:0]     n_q, n_d;
  logic [WDW-1:0]    wd_q, wd_d;
  logic              done_q, done_d, pass_q, pass_d, fail_q, fail_d, tout_q, tout_d;
  logic [IDXW-1:0]   fail_idx_q, fail_idx_d;
  logic [DWIDTH-1:0] fail_got_q, fail_got_d;
  logic [IDXW:0]     cp_q, cp_d;

  logic [DWIDTH-1:0] shadow_q [32];
  entry_t            table_q  [NUM_CHECKS];

  logic              busy, wd_hit, last;
  entry_t            cur;
  logic [DWIDTH-1:0] flag_val, cmp_val;

  assign busy     = (state_q == S_WAIT) || (state_q == S_CMP);
  assign wd_hit   = (TIMEOUT_CYCLES != 0) && busy && (wd_q == WD_LIMIT);
  assign cur      = table_q[idx_q];
  assign flag_val = shadow_q[FLAG_ADDR];
  assign cmp_val  = shadow_q[cur.rnum];
  assign last     = ({1'b0, idx_q} + (IDXW + 1)'(1)) == n_q;

  // NOTE: memories are reset explicitly so a mid-run rst leaves no stale shadow or table data.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) shadow_q[i] <= '0;
      for (int i = 0; i < NUM_CHECKS; i++) table_q[i] <= '0;
    end else begin
      if (bus.wb_we && bus.wb_addr != 5'd0) shadow_q[bus.wb_addr] <= bus.wb_data;
      if (bus.cfg_we && !busy && int'(bus.cfg_idx) < NUM_CHECKS)
        table_q[bus.cfg_idx] <= '{flag: bus.cfg_flag, rnum: bus.cfg_reg, exp: bus.cfg_exp};
    end
  end

  // NOTE: state registers take only non-blocking copies of the _d values computed below.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      idx_q      <= '0;
      n_q        <= '0;
      wd_q       <= '0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      fail_q     <= 1'b0;
      tout_q     <= 1'b0;
      fail_idx_q <= '0;
      fail_got_q <= '0;
      cp_q       <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      n_q        <= n_d;
      wd_q       <= wd_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      fail_q     <= fail_d;
      tout_q     <= tout_d;
      fail_idx_q <= fail_idx_d;
      fail_got_q <= fail_got_d;
      cp_q       <= cp_d;
    end
  end

  // NOTE: every _d gets a hold default first so no path leaves a latch behind.
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    n_d        = n_q;
    wd_d       = wd_q;
    done_d     = done_q;
    pass_d     = pass_q;
    fail_d     = fail_q;
    tout_d     = tout_q;
    fail_idx_d = fail_idx_q;
    fail_got_d = fail_got_q;
    cp_d       = cp_q;

    if (busy && wd_q != WD_SAT) wd_d = wd_q + WDW'(1);

    // The watchdog outranks whatever WAIT or CMP would have decided this cycle.
    if (wd_hit) begin
      state_d    = S_TOUT;
      tout_d     = 1'b1;
      done_d     = 1'b1;
      fail_idx_d = idx_q;
    end else begin
      case (state_q)
        S_WAIT: if (flag_val == cur.flag) state_d = S_CMP;
        S_CMP: begin
          if (cmp_val == cur.exp) begin
            cp_d  = cp_q + (IDXW + 1)'(1);
            idx_d = idx_q + IDXW'(1);
            if (last) begin
              state_d = S_PASS;
              pass_d  = 1'b1;
              done_d  = 1'b1;
            end else begin
              state_d = S_WAIT;
            end
          end else begin
            state_d    = S_FAIL;
            fail_d     = 1'b1;
            done_d     = 1'b1;
            fail_idx_d = idx_q;
            fail_got_d = cmp_val;
          end
        end
        default: begin
          if (bus.start) begin
            idx_d      = '0;
            wd_d       = '0;
            cp_d       = '0;
            fail_idx_d = '0;
            fail_got_d = '0;
            fail_d     = 1'b0;
            tout_d     = 1'b0;
            n_d        = (bus.cfg_num > N_MAX) ? N_MAX : bus.cfg_num;
            if (n_d == '0) begin
              state_d = S_PASS;
              pass_d  = 1'b1;
              done_d  = 1'b1;
            end else begin
              state_d = S_WAIT;
              pass_d  = 1'b0;
              done_d  = 1'b0;
            end
          end
        end
      endcase
    end
  end

  assign bus.busy          = busy;
  assign bus.done          = done_q;
  assign bus.pass          = pass_q;
  assign bus.fail          = fail_q;
  assign bus.timeout       = tout_q;
  assign bus.fail_idx      = fail_idx_q;
  assign bus.fail_got      = fail_got_q;
  assign bus.checks_passed = cp_q;
endmodule
